// File: rtl/bridge_pkg.sv
// Shared types for the sram-like bus bridges: FSM state encoding and bus size codes.
// Pure declarations; no logic and no latency.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/sram_size_enc.sv
// Maps core byte enables to bus {wr, size, addr[1:0]}; purely combinational, no backpressure.
// A zero enable pattern is a word read at a word-aligned address.
module sram_size_enc
    import bridge_pkg::*;
(
    input  logic [3:0] wen_i,
    output logic       wr_o,
    output logic [1:0] size_o,
    output logic [1:0] addr_lo_o
);

    always_comb begin
        wr_o      = |wen_i;
        size_o    = SIZE_W;
        addr_lo_o = 2'b00;
        case (wen_i)
            4'b0001: begin size_o = SIZE_B; addr_lo_o = 2'b00; end
            4'b0010: begin size_o = SIZE_B; addr_lo_o = 2'b01; end
            4'b0100: begin size_o = SIZE_B; addr_lo_o = 2'b10; end
            4'b1000: begin size_o = SIZE_B; addr_lo_o = 2'b11; end
            4'b0011: begin size_o = SIZE_H; addr_lo_o = 2'b00; end
            4'b1100: begin size_o = SIZE_H; addr_lo_o = 2'b10; end
            default: begin size_o = SIZE_W; addr_lo_o = 2'b00; end
        endcase
    end

endmodule

// File: rtl/d_sram_like_bridge.sv
// Core data SRAM port to sram-like bus; one transaction per access, min 2 cycles addr_ok->HOLD.
// Stalls the pipeline until data_ok, then holds read data until the global stall releases.
module d_sram_like_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q;
    logic        enc_wr;
    logic [1:0]  enc_size;
    logic [1:0]  enc_addr_lo;
    logic        unused_addr_lo;

    // Low address bits come from the byte enables, not from the core address.
    assign unused_addr_lo = ^data_sram_addr[1:0];

    sram_size_enc u_size_enc (
        .wen_i     (data_sram_wen),
        .wr_o      (enc_wr),
        .size_o    (enc_size),
        .addr_lo_o (enc_addr_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_req && data_addr_ok) state_d = WAIT;
            WAIT:    if (data_data_ok)             state_d = HOLD;
            HOLD:    if (!longest_stall)           state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_comb begin
        data_req   = data_sram_en && (state_q == IDLE);
        d_stall    = data_sram_en && (state_q != HOLD);
        data_wr    = data_sram_en && enc_wr;
        data_size  = data_sram_en ? enc_size : 2'b00;
        data_addr  = data_sram_en ? {data_sram_addr[ADDR_W-1:2], enc_addr_lo} : '0;
        data_wdata = data_sram_en ? data_sram_wdata : 32'h0;
    end

    // Read data is frozen from data_ok until the next read completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0;
        end else if (state_q == WAIT && data_data_ok && !data_wr) begin
            rdata_q <= data_rdata;
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Bench for d_sram_like_bridge: directed scenarios plus randomized core/slave traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst, en, lstall, dstall, req, wr, addr_ok, data_ok;
    logic [3:0]  wen;
    logic [31:0] addr, wdata, sram_rdata, baddr, bwdata, brdata;
    logic [1:0]  size;

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: accepted-but-unfinished, finished-but-not-released, held read word.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    bit          chk_on = 1'b0;
    bit          adv;

    logic [3:0] pats [10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5};

    always #5 clk = ~clk;

    d_sram_like_bridge #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (sram_rdata),
        .longest_stall   (lstall),
        .d_stall         (dstall),
        .data_req        (req),
        .data_wr         (wr),
        .data_size       (size),
        .data_addr       (baddr),
        .data_wdata      (bwdata),
        .data_addr_ok    (addr_ok),
        .data_data_ok    (data_ok),
        .data_rdata      (brdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {size, addr_lo} from the byte-enable rules.
    function automatic logic [3:0] exp_enc(input logic [3:0] w);
        logic [1:0] s;
        logic [1:0] lo;
        s  = 2'b10;
        lo = 2'b00;
        if ($countones(w) == 1) begin
            s = 2'b00;
            for (int i = 0; i < 4; i++) if (w[i]) lo = 2'(i);
        end else if (w == 4'b0011 || w == 4'b1100) begin
            s  = 2'b01;
            lo = {w[2], 1'b0};
        end
        return {s, lo};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_rdata = 32'h0;
        end else if (m_done) begin
            if (!lstall) m_done = 1'b0;
        end else if (m_busy) begin
            if (data_ok) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                if (wen == 4'h0) m_rdata = brdata;
            end
        end else if (en && addr_ok) begin
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (chk_on) begin
            e = exp_enc(wen);
            chk("req",    32'(req),    32'(en && !m_busy && !m_done));
            chk("d_stall",32'(dstall), 32'(en && !m_done));
            chk("wr",     32'(wr),     32'(en && wen != 4'h0));
            chk("size",   32'(size),   en ? 32'(e[3:2]) : 32'h0);
            chk("addr",   baddr,       en ? {addr[31:2], e[1:0]} : 32'h0);
            chk("wdata",  bwdata,      en ? wdata : 32'h0);
            chk("rdata",  sram_rdata,  m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; wen = w; addr = a; wdata = d; lstall = 1'b1;
    endtask

    task automatic finish(input int aw, input int dw, input int hold, input logic [31:0] rd);
        for (int i = 0; i < aw; i++) begin addr_ok = 1'b0; step(); end
        addr_ok = 1'b1; step();
        addr_ok = 1'b0;
        for (int i = 1; i < dw; i++) step();
        data_ok = 1'b1; brdata = rd; step();
        data_ok = 1'b0;
        for (int i = 0; i < hold; i++) begin lstall = 1'b1; step(); end
        lstall = 1'b0; step();
        en = 1'b0; wen = 4'h0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; lstall = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'h0;
        step();
        chk_on = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_dstall", 32'(dstall), 32'h0);
        chk("rst_rdata", sram_rdata, 32'h0);
        chk("rst_addr", baddr, 32'h0);

        // Fast read
        step();
        start(4'h0, 32'h8000_1234, 32'h0); addr_ok = 1'b1;
        @(negedge clk);
        chk("fr_c0_stall", 32'(dstall), 32'h1);
        chk("fr_size", 32'(size), 32'h2);
        chk("fr_addr", baddr, 32'h8000_1234);
        step();
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("fr_c1_stall", 32'(dstall), 32'h1);
        chk("fr_c1_req", 32'(req), 32'h0);
        step();
        data_ok = 1'b0; lstall = 1'b0;
        @(negedge clk);
        chk("fr_c2_stall", 32'(dstall), 32'h0);
        chk("fr_c2_rdata", sram_rdata, 32'hDEAD_BEEF);
        step();
        en = 1'b0;

        // Byte write then half write
        start(4'b0100, 32'h1000_0000, 32'h00AB_0000);
        @(negedge clk);
        chk("bw_wr", 32'(wr), 32'h1);
        chk("bw_size", 32'(size), 32'h0);
        chk("bw_addr", baddr, 32'h1000_0002);
        finish(0, 1, 0, 32'h1111_1111);
        start(4'b1100, 32'h1000_0000, 32'hABCD_ABCD);
        @(negedge clk);
        chk("hw_size", 32'(size), 32'h1);
        chk("hw_addr", baddr, 32'h1000_0002);
        finish(0, 1, 0, 32'h2222_2222);
        chk("wr_keeps_rdata", sram_rdata, 32'hDEAD_BEEF);

        // Slow slave, then HOLD extension
        start(4'h0, 32'h0000_0040, 32'h0);
        finish(3, 4, 0, 32'h1234_5678);
        chk("slow_rdata", sram_rdata, 32'h1234_5678);
        start(4'h0, 32'h0000_0080, 32'h0);
        finish(0, 1, 5, 32'h5A5A_A5A5);
        chk("hold_rdata", sram_rdata, 32'h5A5A_A5A5);

        // Reset in WAIT, then a late data_ok in IDLE
        start(4'h0, 32'h2000_0010, 32'h0); addr_ok = 1'b1;
        step();
        addr_ok = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1; en = 1'b0; lstall = 1'b0;
        @(negedge clk);
        chk("rstw_req", 32'(req), 32'h0);
        chk("rstw_rdata", sram_rdata, 32'h0);
        data_ok = 1'b1; brdata = 32'hCAFE_F00D;
        step();
        data_ok = 1'b0;
        @(negedge clk);
        chk("late_dok_rdata", sram_rdata, 32'h0);
        step();

        // Back-to-back read then write
        start(4'h0, 32'h3000_0000, 32'h0);
        finish(0, 1, 0, 32'h0BAD_CAFE);
        start(4'hF, 32'h3000_0004, 32'h7777_8888);
        @(negedge clk);
        chk("b2b_req", 32'(req), 32'h1);
        finish(1, 2, 0, 32'h9999_9999);
        chk("b2b_rdata", sram_rdata, 32'h0BAD_CAFE);

        // Random traffic
        adv = 1'b1;
        repeat (3000) begin
            if (adv) begin
                en    = ($urandom_range(0, 2) != 0);
                wen   = pats[$urandom_range(0, 9)];
                addr  = $urandom;
                wdata = $urandom;
            end
            addr_ok = ($urandom_range(0, 2) == 0);
            if (m_busy) data_ok = ($urandom_range(0, 2) == 0);
            else        data_ok = !addr_ok && !m_done && ($urandom_range(0, 7) == 0);
            brdata = $urandom;
            lstall = (en && !m_done) || ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 199) != 0);
            adv    = !lstall || !rst;
            step();
        end
        rst = 1'b1; en = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; lstall = 1'b0;
        step();
        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
